// File: rtl/key_expansion.sv
// Iterative AES key expander: one FIPS-197 schedule word per clock into a round-key store,
// with a registered row-major read port serving any round in forward or decryption order.
module key_expansion #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [KEY_BITS-1:0] key_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                keys_valid_o,
  input  logic [3:0]          rd_round_i,
  input  logic                rd_dec_i,
  output logic [127:0]        rd_key_o
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [5:0] LAST_W  = 6'(NW - 1);
  localparam logic [2:0] NK_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_L    = 4'(NR);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("key_expansion: KEY_BITS must be 128, 192 or 256");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Forward S-box computed as the GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] to_rows(input logic [31:0] c0, input logic [31:0] c1,
                                           input logic [31:0] c2, input logic [31:0] c3);
    return {c0[31:24], c1[31:24], c2[31:24], c3[31:24],
            c0[23:16], c1[23:16], c2[23:16], c3[23:16],
            c0[15:8],  c1[15:8],  c2[15:8],  c3[15:8],
            c0[7:0],   c1[7:0],   c2[7:0],   c3[7:0]};
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_r;
  logic [5:0]  idx_r;
  logic [2:0]  phase_r;
  logic [7:0]  rcon_r;
  logic [31:0] store_r [0:NW-1];

  logic        start_go_s;
  logic        last_word_s;
  logic [31:0] prev_s;
  logic [31:0] old_s;
  logic [31:0] sub_in_s;
  logic [31:0] sub_out_s;
  logic [31:0] temp_s;
  logic [31:0] new_word_s;
  logic [3:0]  rd_j_s;
  logic [5:0]  rd_base_s;
  logic        rd_ok_s;
  logic [127:0] rd_data_s;

  // Next schedule word and read-port selection.
  always_comb begin
    start_go_s  = start_i && (state_r != EXPAND);
    last_word_s = (idx_r == LAST_W);
    prev_s      = store_r[idx_r - 6'd1];
    old_s       = store_r[idx_r - NK_W];
    // phase_r tracks i mod NK so no divider is needed.
    sub_in_s    = (phase_r == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;
    sub_out_s   = sub_word(sub_in_s);
    if (phase_r == 3'd0) begin
      temp_s = sub_out_s ^ {rcon_r, 24'h000000};
    end else if (NK == 8 && phase_r == 3'd4) begin
      temp_s = sub_out_s;
    end else begin
      temp_s = prev_s;
    end
    new_word_s = old_s ^ temp_s;

    rd_j_s    = rd_dec_i ? (NR_L - rd_round_i) : rd_round_i;
    rd_base_s = {rd_j_s, 2'b00};
    rd_ok_s   = keys_valid_o && (rd_round_i <= NR_L);
    if (rd_ok_s) begin
      rd_data_s = to_rows(store_r[rd_base_s], store_r[rd_base_s + 6'd1],
                          store_r[rd_base_s + 6'd2], store_r[rd_base_s + 6'd3]);
    end else begin
      rd_data_s = 128'h0;
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      keys_valid_o <= 1'b0;
      idx_r        <= 6'd0;
      phase_r      <= 3'd0;
      rcon_r       <= 8'h01;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start_i) begin
            state_r      <= EXPAND;
            idx_r        <= NK_W;
            phase_r      <= 3'd0;
            rcon_r       <= 8'h01;
            keys_valid_o <= 1'b0;
            busy_o       <= 1'b1;
          end
        end
        EXPAND: begin
          idx_r   <= idx_r + 6'd1;
          phase_r <= (phase_r == NK_LAST) ? 3'd0 : phase_r + 3'd1;
          if (phase_r == 3'd0) rcon_r <= xtime(rcon_r);
          if (last_word_s) begin
            state_r      <= DONE;
            busy_o       <= 1'b0;
            keys_valid_o <= 1'b1;
            done_o       <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  // Round-key store: key words on a start edge, one expanded word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (!rst && start_go_s) begin
      for (int n = 0; n < NK; n++) begin
        store_r[n] <= key_i[KEY_BITS-1-32*n -: 32];
      end
    end else if (!rst && state_r == EXPAND) begin
      store_r[idx_r] <= new_word_s;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_o <= 128'h0;
    end else begin
      rd_key_o <= rd_data_s;
    end
  end

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: one instance per key size, FIPS-197 vectors,
// latency/done checks and a read-port scoreboard.
module tb_key_expansion;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   start;
  logic [3:0]   rd_round;
  logic         rd_dec;
  logic [127:0] k128;
  logic [191:0] k192;
  logic [255:0] k256;
  wire  [2:0]   busy;
  wire  [2:0]   done;
  wire  [2:0]   valid;
  wire  [127:0] rd_key [3];

  typedef struct {
    int           u;
    logic [127:0] exp;
    string        tag;
  } sb_t;

  sb_t sb_q[$];
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  key_expansion #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst(rst), .start_i(start[0]), .key_i(k128), .busy_o(busy[0]),
    .done_o(done[0]), .keys_valid_o(valid[0]), .rd_round_i(rd_round), .rd_dec_i(rd_dec),
    .rd_key_o(rd_key[0]));

  key_expansion #(.KEY_BITS(192)) u192 (
    .clk(clk), .rst(rst), .start_i(start[1]), .key_i(k192), .busy_o(busy[1]),
    .done_o(done[1]), .keys_valid_o(valid[1]), .rd_round_i(rd_round), .rd_dec_i(rd_dec),
    .rd_key_o(rd_key[1]));

  key_expansion #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst(rst), .start_i(start[2]), .key_i(k256), .busy_o(busy[2]),
    .done_o(done[2]), .keys_valid_o(valid[2]), .rd_round_i(rd_round), .rd_dec_i(rd_dec),
    .rd_key_o(rd_key[2]));

  function automatic logic [127:0] rows(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
    return {c0[31:24], c1[31:24], c2[31:24], c3[31:24],
            c0[23:16], c1[23:16], c2[23:16], c3[23:16],
            c0[15:8],  c1[15:8],  c2[15:8],  c3[15:8],
            c0[7:0],   c1[7:0],   c2[7:0],   c3[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One read per cycle: compare the result of the previous request, then issue the next.
  task automatic rd_step(input int u, input int rnd, input logic dec, input logic [127:0] exp,
                         input string tag, input bit push);
    sb_t e;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, rd_key[e.u], e.exp);
    end
    if (push) begin
      rd_round = 4'(rnd);
      rd_dec   = dec;
      e.u   = u;
      e.exp = exp;
      e.tag = tag;
      sb_q.push_back(e);
    end
  endtask

  task automatic run_exp(input int u, input int lat, input int pulse_at, input string tag);
    int cnt;
    int ndone;
    cnt   = 0;
    ndone = 0;
    @(negedge clk);
    start[u] = 1'b1;
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    start[u] = 1'b0;
    ndone += int'(done[u]);
    chk({tag, "_busy"}, busy[u], 1'b1);
    chk({tag, "_valid_lo"}, valid[u], 1'b0);
    while (valid[u] !== 1'b1 && cnt < 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      ndone += int'(done[u]);
      start[u] = (cnt == pulse_at);
    end
    start[u] = 1'b0;
    chk({tag, "_latency"}, 128'(cnt), 128'(lat));
    chk({tag, "_busy_end"}, busy[u], 1'b0);
    repeat (3) begin
      @(negedge clk);
      ndone += int'(done[u]);
    end
    chk({tag, "_done_pulses"}, 128'(ndone), 128'd1);
    chk({tag, "_valid_hold"}, valid[u], 1'b1);
  endtask

  initial begin
    logic [127:0] r128_0, r128_1, r128_10, r192_0, r192_1, r192_12, r256_1, r256_2, r256_14;
    r128_0  = rows(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
    r128_1  = rows(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605);
    r128_10 = rows(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6);
    r192_0  = rows(32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5);
    r192_1  = rows(32'h62f8ead2, 32'h522c6b7b, 32'hfe0c91f7, 32'h2402f5a5);
    r192_12 = rows(32'he98ba06f, 32'h448c773c, 32'h8ecc7204, 32'h01002202);
    r256_1  = rows(32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4);
    r256_2  = rows(32'h9ba35411, 32'h8e6925af, 32'ha51a8b5f, 32'h2067fcde);
    r256_14 = rows(32'hfe4890d1, 32'he6188d0b, 32'h046df344, 32'h706c631e);

    rst      = 1'b1;
    start    = 3'b000;
    rd_round = 4'd0;
    rd_dec   = 1'b0;
    k128 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    k192 = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
    k256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst_busy%0d", u), busy[u], 1'b0);
      chk($sformatf("rst_done%0d", u), done[u], 1'b0);
      chk($sformatf("rst_valid%0d", u), valid[u], 1'b0);
      chk($sformatf("rst_rdkey%0d", u), rd_key[u], 128'h0);
    end
    rd_step(0, 0, 1'b0, 128'h0, "rd_before_valid", 1'b1);
    rd_step(0, 0, 1'b0, 128'h0, "", 1'b0);

    run_exp(0, 41, 0, "k128");
    rd_step(0, 0, 1'b0, r128_0, "k128_r0", 1'b1);
    rd_step(0, 1, 1'b0, r128_1, "k128_r1", 1'b1);
    rd_step(0, 10, 1'b0, r128_10, "k128_r10", 1'b1);
    rd_step(0, 0, 1'b1, r128_10, "k128_dec0", 1'b1);
    rd_step(0, 10, 1'b1, r128_0, "k128_dec10", 1'b1);
    rd_step(0, 11, 1'b0, 128'h0, "k128_r11_zero", 1'b1);
    rd_step(0, 11, 1'b1, 128'h0, "k128_dec11_zero", 1'b1);
    rd_step(0, 0, 1'b0, 128'h0, "", 1'b0);

    run_exp(1, 47, 10, "k192_midpulse");
    rd_step(1, 0, 1'b0, r192_0, "k192_r0", 1'b1);
    rd_step(1, 1, 1'b0, r192_1, "k192_r1", 1'b1);
    rd_step(1, 12, 1'b0, r192_12, "k192_r12", 1'b1);
    rd_step(1, 12, 1'b1, r192_0, "k192_dec12", 1'b1);
    rd_step(1, 13, 1'b0, 128'h0, "k192_r13_zero", 1'b1);
    rd_step(1, 0, 1'b0, 128'h0, "", 1'b0);

    run_exp(2, 53, 0, "k256");
    rd_step(2, 1, 1'b0, r256_1, "k256_r1", 1'b1);
    rd_step(2, 2, 1'b0, r256_2, "k256_r2", 1'b1);
    rd_step(2, 14, 1'b0, r256_14, "k256_r14", 1'b1);
    rd_step(2, 0, 1'b1, r256_14, "k256_dec0", 1'b1);
    rd_step(2, 15, 1'b0, 128'h0, "k256_r15_zero", 1'b1);
    rd_step(2, 0, 1'b0, 128'h0, "", 1'b0);

    run_exp(0, 41, 0, "k128_restart");
    rd_step(0, 10, 1'b0, r128_10, "k128_restart_r10", 1'b1);
    rd_step(0, 0, 1'b0, 128'h0, "", 1'b0);

    // Abort a run with reset partway through expansion.
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    rd_round = 4'd10;
    repeat (19) @(negedge clk);
    chk("abort_busy_before", busy[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_valid", valid[0], 1'b0);
    chk("abort_rdkey", rd_key[0], 128'h0);
    repeat (60) @(negedge clk);
    chk("abort_valid_stays_low", valid[0], 1'b0);
    chk("abort_rdkey_stays_zero", rd_key[0], 128'h0);
    run_exp(0, 41, 0, "k128_after_rst");
    rd_step(0, 10, 1'b0, r128_10, "k128_after_rst_r10", 1'b1);
    rd_step(0, 0, 1'b0, 128'h0, "", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
